// File: rtl/sram_1r1w.sv
// sram_1r1w: register-file memory with one write port and two registered read ports.
// A read that hits the word being written returns the new data (write-first).
module sram_1r1w #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 4096,
  parameter     INIT_FILE  = ""
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  WE,
  input  logic [ADDR_WIDTH-1:0] WriteAddress,
  input  logic [DATA_WIDTH-1:0] WriteBus,
  input  logic [ADDR_WIDTH-1:0] ReadAddress1,
  input  logic [ADDR_WIDTH-1:0] ReadAddress2,
  output logic [DATA_WIDTH-1:0] ReadBus1,
  output logic [DATA_WIDTH-1:0] ReadBus2
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH + 1)'(DEPTH);

  reg [DATA_WIDTH-1:0] Register [0:DEPTH-1];

  logic                  wa_ok;
  logic                  ra1_ok;
  logic                  ra2_ok;
  logic                  we_ok;
  logic [IW-1:0]         wa_idx;
  logic [IW-1:0]         ra1_idx;
  logic [IW-1:0]         ra2_idx;
  logic [DATA_WIDTH-1:0] rb1_d;
  logic [DATA_WIDTH-1:0] rb1_q;
  logic [DATA_WIDTH-1:0] rb2_d;
  logic [DATA_WIDTH-1:0] rb2_q;

  // Addresses at or beyond DEPTH never touch the array.
  always_comb begin
    wa_ok   = {1'b0, WriteAddress} < LIMIT;
    ra1_ok  = {1'b0, ReadAddress1} < LIMIT;
    ra2_ok  = {1'b0, ReadAddress2} < LIMIT;
    wa_idx  = WriteAddress[IW-1:0];
    ra1_idx = ReadAddress1[IW-1:0];
    ra2_idx = ReadAddress2[IW-1:0];
    we_ok   = WE && wa_ok && !reset;
  end

  always_comb begin
    rb1_d = '0;
    if (!reset && ra1_ok) begin
      if (we_ok && ReadAddress1 == WriteAddress)
        rb1_d = WriteBus;
      else
        rb1_d = Register[ra1_idx];
    end
  end

  always_comb begin
    rb2_d = '0;
    if (!reset && ra2_ok) begin
      if (we_ok && ReadAddress2 == WriteAddress)
        rb2_d = WriteBus;
      else
        rb2_d = Register[ra2_idx];
    end
  end

  always_ff @(posedge clock) begin
    rb1_q <= rb1_d;
    rb2_q <= rb2_d;
  end

  // Array is never cleared so preloaded contents survive reset.
  always_ff @(posedge clock) begin
    if (we_ok)
      Register[wa_idx] <= WriteBus;
  end

  assign ReadBus1 = rb1_q;
  assign ReadBus2 = rb2_q;

endmodule

// File: tb/tb_sram_1r1w.sv
// tb_sram_1r1w: directed vector table, hand sequences and random traffic
// checked against an array model of the memory (DEPTH=4000).
module tb_sram_1r1w;

  localparam int DW = 32;
  localparam int AW = 12;
  localparam int DEPTH = 4000;

  logic          clock = 1'b0;
  logic          reset;
  logic          WE;
  logic [AW-1:0] WriteAddress;
  logic [DW-1:0] WriteBus;
  logic [AW-1:0] ReadAddress1;
  logic [AW-1:0] ReadAddress2;
  logic [DW-1:0] ReadBus1;
  logic [DW-1:0] ReadBus2;

  sram_1r1w #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .DEPTH(DEPTH),
    .INIT_FILE("")
  ) dut (
    .clock(clock),
    .reset(reset),
    .WE(WE),
    .WriteAddress(WriteAddress),
    .WriteBus(WriteBus),
    .ReadAddress1(ReadAddress1),
    .ReadAddress2(ReadAddress2),
    .ReadBus1(ReadBus1),
    .ReadBus2(ReadBus2)
  );

  always #5 clock = ~clock;

  logic [DW-1:0] mem [0:4095];
  bit            known [0:4095];

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic          rst;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wb;
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
    logic [DW-1:0] e1;
    logic [DW-1:0] e2;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic void model_read(input logic rst, input logic we,
                                     input int wa, input logic [DW-1:0] wb,
                                     input int ra, output logic [DW-1:0] v,
                                     output bit k);
    k = 1'b1;
    v = '0;
    if (rst || ra >= DEPTH) v = '0;
    else if (we && wa < DEPTH && wa == ra) v = wb;
    else begin
      v = mem[ra];
      k = known[ra];
    end
  endfunction

  task automatic preload(input int a, input logic [DW-1:0] v);
    dut.Register[a] <= v;
    mem[a] = v;
    known[a] = 1'b1;
  endtask

  task automatic cycle(input logic rst, input logic we, input int wa,
                       input logic [DW-1:0] wb, input int ra1, input int ra2,
                       output logic [DW-1:0] m1, output logic [DW-1:0] m2,
                       output bit k1, output bit k2);
    reset = rst;
    WE = we;
    WriteAddress = AW'(wa);
    WriteBus = wb;
    ReadAddress1 = AW'(ra1);
    ReadAddress2 = AW'(ra2);
    model_read(rst, we, wa, wb, ra1, m1, k1);
    model_read(rst, we, wa, wb, ra2, m2, k2);
    if (!rst && we && wa < DEPTH) begin
      mem[wa] = wb;
      known[wa] = 1'b1;
    end
    @(posedge clock);
    #1;
  endtask

  function automatic int rand_addr();
    if ($urandom_range(0, 9) == 0) return 3990 + int'($urandom_range(0, 105));
    return int'($urandom_range(0, 31));
  endfunction

  initial begin
    logic [DW-1:0] m1, m2;
    bit k1, k2;
    int wa, ra1, ra2;
    logic rst, we;
    logic [DW-1:0] wb;

    for (int i = 0; i < 4096; i++) begin
      mem[i] = '0;
      known[i] = 1'b0;
    end

    vecs[0]  = '{1'b0, 1'b1, 12'd10,   32'hDEADBEEF, 12'd0,    12'd1,
                 32'h1,        32'h2};
    vecs[1]  = '{1'b0, 1'b0, 12'd0,    32'h0,        12'd10,   12'd11,
                 32'hDEADBEEF, 32'hB0B};
    vecs[2]  = '{1'b0, 1'b1, 12'd5,    32'h22,       12'd5,    12'd5,
                 32'h22,       32'h22};
    vecs[3]  = '{1'b0, 1'b0, 12'd0,    32'h0,        12'd5,    12'd0,
                 32'h22,       32'h1};
    vecs[4]  = '{1'b0, 1'b1, 12'd4095, 32'hCAFE,     12'd4095, 12'd10,
                 32'h0,        32'hDEADBEEF};
    vecs[5]  = '{1'b0, 1'b1, 12'd3999, 32'h3999,     12'd4000, 12'd2,
                 32'h0,        32'h3};
    vecs[6]  = '{1'b0, 1'b0, 12'd0,    32'h0,        12'd3999, 12'd4095,
                 32'h3999,     32'h0};
    vecs[7]  = '{1'b0, 1'b0, 12'd10,   32'h1234,     12'd10,   12'd10,
                 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[8]  = '{1'b1, 1'b1, 12'd10,   32'h777,      12'd10,   12'd11,
                 32'h0,        32'h0};
    vecs[9]  = '{1'b0, 1'b0, 12'd0,    32'h0,        12'd10,   12'd7,
                 32'hDEADBEEF, 32'h99};
    vecs[10] = '{1'b0, 1'b1, 12'd3,    32'hA5A5,     12'd3,    12'd2,
                 32'hA5A5,     32'h3};
    vecs[11] = '{1'b0, 1'b0, 12'd0,    32'h0,        12'd3,    12'd3,
                 32'hA5A5,     32'hA5A5};

    preload(0, 32'h1);
    preload(1, 32'h2);
    preload(2, 32'h3);
    preload(3, 32'h4);
    preload(5, 32'h11);
    preload(7, 32'h99);
    preload(11, 32'hB0B);

    // Reset held two cycles with a write to [7] that must be dropped.
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'b1, 7, 32'h55, 2, 3, m1, m2, k1, k2);
      check("rst_rb1", ReadBus1, 32'h0);
      check("rst_rb2", ReadBus2, 32'h0);
    end
    cycle(1'b0, 1'b0, 0, 32'h0, 2, 3, m1, m2, k1, k2);
    check("post_rst_rb1", ReadBus1, 32'h3);
    check("post_rst_rb2", ReadBus2, 32'h4);
    cycle(1'b0, 1'b0, 0, 32'h0, 7, 7, m1, m2, k1, k2);
    check("rst_drop_rb1", ReadBus1, 32'h99);
    check("rst_drop_rb2", ReadBus2, 32'h99);

    for (int i = 0; i < 12; i++) begin
      cycle(vecs[i].rst, vecs[i].we, int'(vecs[i].wa), vecs[i].wb,
            int'(vecs[i].ra1), int'(vecs[i].ra2), m1, m2, k1, k2);
      check($sformatf("vec%0d_rb1", i), ReadBus1, vecs[i].e1);
      check($sformatf("vec%0d_rb2", i), ReadBus2, vecs[i].e2);
    end

    // Back-to-back writes, each read in the same cycle through the bypass.
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 1'b1, i, DW'(i * 3), i, i, m1, m2, k1, k2);
      check($sformatf("bypass%0d_rb1", i), ReadBus1, DW'(i * 3));
      check($sformatf("bypass%0d_rb2", i), ReadBus2, DW'(i * 3));
    end
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 1'b0, 0, 32'h0, i, 15 - i, m1, m2, k1, k2);
      check($sformatf("sweep%0d_rb1", i), ReadBus1, DW'(i * 3));
      check($sformatf("sweep%0d_rb2", i), ReadBus2, DW'((15 - i) * 3));
    end

    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 29) == 0);
      we  = 1'($urandom_range(0, 1));
      wa  = rand_addr();
      wb  = $urandom;
      ra1 = ($urandom_range(0, 3) == 0) ? wa : rand_addr();
      ra2 = ($urandom_range(0, 3) == 0) ? wa : rand_addr();
      cycle(rst, we, wa, wb, ra1, ra2, m1, m2, k1, k2);
      if (k1) check($sformatf("rand%0d_rb1", n), ReadBus1, m1);
      if (k2) check($sformatf("rand%0d_rb2", n), ReadBus2, m2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
